// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a small byte FIFO and cts flow control.
// Bytes enter through a valid/ready handshake. They are sent LSB first at
// BIT_CLK system clocks per bit, with STOP_BITS stop bits.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte and cts
// START | start bit (low) for BIT_CLK cycles
// DATA  | eight data bits, LSB first
// STOP  | stop bit(s) high; the next queued byte may start straight from here
module uart_tx #(
    parameter int BIT_CLK    = 87,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] txdata,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       cts,
    output logic       txd,
    output logic       busy
);
    localparam int CNT_W = $clog2(BIT_CLK);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CLK - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             cts_meta_q, cts_s_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [7:0]       fifo_mem_q [FIFO_DEPTH];

    logic push;
    logic pop;
    logic full;
    logic non_empty;
    logic bit_end;
    logic can_start;

    assign full      = (occ_q == OCC_FULL);
    assign non_empty = (occ_q != '0);
    assign push      = tx_valid && !full;
    assign bit_end   = (cnt_q == CNT_LAST);
    assign can_start = non_empty && cts_s_q;

    assign tx_ready = !full;
    assign txd      = txd_q;
    assign busy     = non_empty || (state_q != IDLE);

    // Two-flop synchronizer for the asynchronous cts input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cts_meta_q <= 1'b0;
            cts_s_q    <= 1'b0;
        end else begin
            cts_meta_q <= cts;
            cts_s_q    <= cts_meta_q;
        end
    end

    // FIFO storage; it needs no reset because occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= txdata;
        end
    end

    // Next FIFO pointers and occupancy. A pop does not free space for a push
    // on the same edge when the FIFO is full.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!push && pop) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    // Next state, bit timing and the registered line value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (can_start) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == STOP_LAST) begin
                        // The idx counter counts stop bits in this state.
                        idx_d = '0;
                        if (can_start) begin
                            pop     = 1'b1;
                            shift_d = fifo_mem_q[rd_ptr_q];
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[idx_d];
            default: txd_d = 1'b1;
        endcase
    end

    // State, pointer and line registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx. Pushed bytes go into an expected queue; a line monitor
// decodes frames on txd and checks each one against the head of that queue.
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] txdata = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       cts = 1'b1;
    logic       txd;
    logic       busy;

    logic [7:0] txdata2 = 8'h00;
    logic       tx_valid2 = 1'b0;
    logic       tx_ready2;
    logic       cts2 = 1'b1;
    logic       txd2;
    logic       busy2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int frames_done = 0;
    logic [7:0] exp_q [$];
    int starts [$];

    uart_tx #(.BIT_CLK(4), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .txdata(txdata), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .cts(cts), .txd(txd), .busy(busy)
    );

    uart_tx #(.BIT_CLK(87), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .txdata(txdata2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .cts(cts2), .txd(txd2), .busy(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int start_at(input int i);
        if (i < starts.size()) return starts[i];
        return -1;
    endfunction

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        int w = 0;
        while (frames_done < n && w < budget) begin
            @(negedge clk);
            w++;
        end
        check(name, frames_done, n);
    endtask

    // Holds the byte until the DUT takes it; edge_n is the accepting edge.
    task automatic push_byte(input logic [7:0] b, input int max_wait, output int edge_n);
        logic rdy;
        int w = 0;
        edge_n = -1;
        @(negedge clk);
        txdata   = b;
        tx_valid = 1'b1;
        while (edge_n < 0 && w <= max_wait) begin
            rdy = tx_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                edge_n = cyc;
                exp_q.push_back(b);
            end else begin
                @(negedge clk);
                w++;
            end
        end
        tx_valid = 1'b0;
        if (edge_n < 0) check("push_timeout", 0, 1);
    endtask

    // Line monitor: samples txd once per cycle, decodes each 40-cycle frame.
    initial begin : monitor
        logic [39:0] w;
        logic [7:0]  b;
        logic [7:0]  e;
        int          st;
        int          bad;
        logic        aborted;
        forever begin
            @(negedge clk);
            if (rst_n && txd == 1'b0) begin
                st = cyc;
                starts.push_back(st);
                aborted = 1'b0;
                w = '0;
                for (int k = 0; k < 40; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    w[k] = txd;
                end
                if (!aborted) begin
                    bad = 0;
                    for (int k = 0; k < 40; k++)
                        if (w[k] != w[(k / 4) * 4 + 2]) bad++;
                    if (w[2] != 1'b0) bad++;
                    if (w[38] != 1'b1) bad++;
                    for (int i = 0; i < 8; i++) b[i] = w[(i + 1) * 4 + 2];
                    check("frame_shape", bad, 0);
                    if (exp_q.size() == 0) begin
                        check("frame_unexpected", int'(b), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_byte", int'(b), int'(e));
                    end
                    frames_done++;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int e0, e1, e2, s, c, r, n6, bad, stop_hi, lows, n_starts, f, kk, j;
        logic expb;
        logic [7:0] d6;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txd", txd, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single byte 0xA5, latency and busy fall
        push_byte(8'hA5, 2, e0);
        wait_cyc(e0 + 40);
        check("t1_busy_last", busy, 1);
        @(negedge clk);
        check("t1_busy_fall", busy, 0);
        check("t1_txd_idle", txd, 1);
        check("t1_frames", frames_done, 1);
        check("t1_latency", start_at(0), e0 + 1);

        // Back-to-back frames, no gaps, tx_ready stays high
        push_byte(8'h00, 2, e0);
        push_byte(8'hFF, 2, e1);
        push_byte(8'h55, 2, e2);
        check("t2_push_consec", e2 - e0, 2);
        lows = 0;
        while (cyc < e0 + 122) begin
            @(negedge clk);
            if (!tx_ready) lows++;
        end
        check("t2_ready_high", lows, 0);
        check("t2_frames", frames_done, 4);
        check("t2_start0", start_at(1), e0 + 1);
        check("t2_start1", start_at(2), e0 + 41);
        check("t2_start2", start_at(3), e0 + 81);

        // cts low: FIFO fills, fifth byte held off, then released in order
        @(negedge clk);
        cts = 1'b0;
        repeat (3) @(negedge clk);
        push_byte(8'h11, 2, e0);
        push_byte(8'h22, 2, e0);
        push_byte(8'h33, 2, e0);
        push_byte(8'h44, 2, e0);
        @(negedge clk);
        check("t3_full", tx_ready, 0);
        txdata = 8'hEE;
        tx_valid = 1'b1;
        lows = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx_ready) lows++;
        end
        tx_valid = 1'b0;
        check("t3_full_hold", lows, 0);
        check("t3_no_start", starts.size(), 4);
        cts = 1'b1;
        c = cyc;
        push_byte(8'hEE, 10, e1);
        check("t3_fifth_push", e1, c + 4);
        wait_frames(9, 300, "t3_frames");
        check("t3_cts_start", start_at(4), c + 3);
        check("t3_queue_empty", exp_q.size(), 0);

        // cts dropped mid-frame: frame completes, next waits for cts
        repeat (3) @(negedge clk);
        push_byte(8'h96, 2, e0);
        push_byte(8'h3A, 2, e1);
        push_byte(8'hC3, 2, e1);
        s = e0 + 1;
        wait_cyc(s + 17);
        cts = 1'b0;
        wait_frames(10, 60, "t4_first_done");
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (!txd) lows++;
        end
        check("t4_hold_high", lows, 0);
        check("t4_no_start", starts.size(), 10);
        check("t4_first_start", start_at(9), s);
        cts = 1'b1;
        r = cyc;
        wait_frames(12, 120, "t4_frames");
        check("t4_resume", start_at(10), r + 3);
        check("t4_b2b", start_at(11), r + 43);

        // Reset mid-DATA with bytes queued
        repeat (3) @(negedge clk);
        push_byte(8'h5A, 2, e0);
        push_byte(8'h0F, 2, e1);
        push_byte(8'hF0, 2, e1);
        s = e0 + 1;
        wait_cyc(s + 14);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_async_txd", txd, 1);
        check("t5_async_busy", busy, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        n_starts = starts.size();
        @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_ready", tx_ready, 1);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (!txd) lows++;
        end
        check("t5_silent", lows, 0);
        check("t5_no_frames", starts.size(), n_starts);

        // BIT_CLK=87, STOP_BITS=2: two frames of 957 cycles each
        d6 = 8'h3C;
        @(negedge clk);
        check("t6_ready", tx_ready2, 1);
        txdata2 = d6;
        tx_valid2 = 1'b1;
        @(posedge clk);
        #1 n6 = cyc;
        @(negedge clk);
        @(posedge clk);
        #1 tx_valid2 = 1'b0;
        bad = 0;
        stop_hi = 0;
        for (int k = 0; k < 1914; k++) begin
            @(negedge clk);
            f  = k / 957;
            kk = k % 957;
            j  = kk / 87;
            if (j == 0) expb = 1'b0;
            else if (j <= 8) expb = d6[j - 1];
            else expb = 1'b1;
            if (txd2 != expb) bad++;
            if (f == 0 && kk >= 783 && txd2) stop_hi++;
            if (k == 957) check("t6_frame_len", txd2, 0);
            if (k == 0) check("t6_latency", cyc, n6 + 1);
        end
        check("t6_wave", bad, 0);
        check("t6_stop_len", stop_hi, 174);
        check("t6_busy_last", busy2, 1);
        @(negedge clk);
        check("t6_busy_fall", busy2, 0);
        check("t6_txd_idle", txd2, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter, 8N1 framing (optionally 2 stop bits), LSB first; the sending end of the team's serial link.
- A small byte FIFO accepts bytes over a valid/ready handshake.
- Serializes bytes onto txd at BIT_CLK system clocks per bit.
- Hardware flow control via a cts input, sampled only at frame boundaries.

Parameters:
- BIT_CLK, 87, system clocks per serial bit (>= 2); 87 gives 115200 baud at 10 MHz.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, 2..16.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- txdata  input  8  byte to transmit.
- tx_valid  input  1  txdata is valid this cycle.
- tx_ready  output  1  FIFO can accept a byte; equals !full.
- cts  input  1  peer clear-to-send, high = send allowed; asynchronous to clk.
- txd  output  1  serial line, idle high; driven directly from a flop.
- busy  output  1  high while the FIFO is non-empty or a frame is in progress.

Behaviour:
- Reset (rst_n low, asynchronous):
  - txd=1, tx_ready=1, busy=0.
  - FIFO emptied; state IDLE; bit counter, bit index and cts synchronizer cleared to 0.
  - A reset mid-frame aborts the frame immediately; txd goes high with no clock edge required.
- Push:
  - A byte is written on a rising edge where tx_valid && tx_ready.
  - No write when full: tx_valid is ignored and the data is dropped; the sender must hold it.
  - No full-bypass: a pop on the same edge does not allow a push while full.
  - A push and a pop on the same edge, when not full, are both honoured; occupancy is unchanged.
- cts: passed through a 2-flop synchronizer; cts_s is the synchronized value.
- State machine, with bit counter cnt (0..BIT_CLK-1):
  - IDLE: txd=1. If FIFO non-empty and cts_s=1: pop the head into the shift register, go to START, cnt=0.
  - START: txd=0 for BIT_CLK cycles. At cnt==BIT_CLK-1, go to DATA, index=0.
  - DATA: txd=shift[index], each bit held BIT_CLK cycles. Index increments at cnt==BIT_CLK-1. After index 7 completes, go to STOP.
  - STOP: txd=1 for STOP_BITS*BIT_CLK cycles. On the last cycle:
    - if FIFO non-empty and cts_s=1, pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
  - Illegal state encodings recover to IDLE on the next edge with txd=1.
- Timing:
  - txd is registered and changes only on the edge where state or index changes. No glitches.
  - Frame length is exactly (10 + STOP_BITS - 1) * BIT_CLK cycles.
  - Latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE and cts_s=1 is popped at edge N+1; txd falls after edge N+1.
- Flow control:
  - cts_s is evaluated only when deciding to start a frame, in IDLE or on the last STOP cycle.
  - cts dropping mid-frame never truncates the frame; the current byte completes.
  - After cts rises, transmission starts within 3 clk edges (2 synchronizer edges + 1 pop edge).
- Storage:
  - FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter is width clog2(FIFO_DEPTH)+1.
  - Popped data comes from the registered head entry; no combinational path from txdata to txd.
- busy deasserts on the edge that enters IDLE with an empty FIFO.

Test Plan (BIT_CLK=4 unless noted):
- Reset, then push 0xA5 with cts=1 -> txd low 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then high 4 cycles. busy falls at frame end. Total 40 cycles.
- Push 0x00, 0xFF, 0x55 back-to-back with cts=1 -> three 40-cycle frames with no gap between stop and next start. tx_ready stays high throughout (depth 4).
- Hold cts=0, push 5 bytes -> 4 accepted; tx_ready low after the 4th; the 5th is accepted only after a pop. Raise cts -> first start bit within 3 cycles, and bytes go out in order.
- Drop cts at bit 3 of a frame with 2 bytes queued -> the current frame completes intact, txd stays high afterwards, and the next frame starts 3 cycles after cts returns high.
- Assert rst_n=0 mid-DATA with 2 bytes queued -> txd=1 immediately with no clk edge; after release busy=0, tx_ready=1, and no further frames are sent.
- STOP_BITS=2, BIT_CLK=87: push 0x3C -> stop phase lasts 174 cycles; total frame is 957 cycles.
